pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//   Inverse of edge detection: turns single-cycle event pulses (per channel) back into
//   level signals held for a fixed number of enable ticks.
//   Used to gate sound-effect channels, flash/blink indicators and hold-off windows
//   from one-shot game events.
//   Channels are independent; an aggregate busy flag reports any channel active.
// PARAMETERS
//   WIDTH      1   number of independent channels
//   LENGTH     16  hold duration in enable ticks; legal range 1..2**16-1
//   RETRIGGER  1   1: trig while active reloads the count; 0: trig while active ignored
//   ACTIVE_LOW 0   0: out high while active; 1: out low while active
// PORTS
//   clk     in   1      clock
//   rst     in   1      reset, synchronous, active-high
//   enable  in   1      tick strobe; counters advance only on cycles with enable=1
//   trig    in   WIDTH  per-channel start pulse, sampled every clk (independent of enable)
//   out     out  WIDTH  per-channel stretched level, registered, polarity per ACTIVE_LOW
//   busy    out  1      1 when any channel is active (OR of channel states, from registers)
// BEHAVIOUR
//   - Per channel: counter cnt, width CW=$clog2(LENGTH+1).
//     Channel is active iff cnt!=0. Two states:
//       IDLE (cnt==0)
//       ACTIVE (cnt!=0)
//   - Reset: all cnt=0; out={WIDTH{ACTIVE_LOW?1:0}}; busy=0.
//     trig and enable are ignored while rst=1. Reset mid-pulse: out goes inactive
//     on the next edge; there is no residual count.
//   - IDLE, trig=1: cnt<=LENGTH; out goes active on the next edge (latency 1 clk).
//     A simultaneous enable is not counted in the load cycle.
//   - IDLE, trig=0: hold.
//   - ACTIVE, trig=0, enable=1: cnt<=cnt-1. When cnt==1 this moves the channel to
//     IDLE and out goes inactive on that edge.
//   - ACTIVE, trig=0, enable=0: hold.
//   - ACTIVE, trig=1, RETRIGGER=1: cnt<=LENGTH. The reload takes priority over a
//     simultaneous enable decrement; out stays active with no gap.
//   - ACTIVE, trig=1, RETRIGGER=0: trig is ignored; normal decrement/hold applies.
//   - Net timing: out goes active the cycle after trig, then inactive on the edge of
//     the LENGTH-th enable tick after the load cycle.
//     With enable tied 1, out is active exactly LENGTH cycles.
//   - trig held high for several cycles:
//       RETRIGGER=1: reloads every cycle, so out stays active until LENGTH ticks
//         after trig falls.
//       RETRIGGER=0: acts as one trigger plus fresh triggers whenever the channel
//         returns to IDLE.
//   - out[i] = ACTIVE_LOW ? ~(cnt_i!=0) : (cnt_i!=0). Implemented as a flop updated
//     with cnt, never as a combinational decode of next-state.
//   - busy = |active[WIDTH-1:0], registered, same cycle alignment as out.
//   - Counters never underflow; decrement occurs only when cnt!=0.
//     Each channel is fully independent.
// TESTING
//   1. WIDTH=1 LENGTH=4 enable=1, trig pulse at cycle 10
//      -> out=1 cycles 11-14, 0 at 15; busy mirrors out.
//   2. LENGTH=4, enable 1-in-4 (cycles 12,16,20,24), trig at 10
//      -> out=1 from 11, falls at edge of cycle 24.
//   3. LENGTH=4 enable=1, trig at 10 and 12
//      -> RETRIGGER=1: out=1 cycles 11-16; RETRIGGER=0: out=1 cycles 11-14.
//   4. ACTIVE_LOW=1 LENGTH=3
//      -> out=1 during/after reset; trig at 5 -> out=0 cycles 6-8, 1 at 9.
//   5. WIDTH=4 LENGTH=2: trig=4'b0101 at 10, trig=4'b1000 at 11
//      -> out=0101 at 11, 1101 at 12, 1000 at 13, 0000 at 14; busy=1 cycles 11-13.
//   6. LENGTH=8, trig at 10, rst=1 at cycle 13 with trig=1
//      -> out inactive from 14, busy=0, no pulse after rst falls until a new trig.

Source files
------------

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches single-cycle trigger pulses into levels held for LENGTH enable ticks
module pulse_stretcher #(
   parameter int WIDTH      = 1,
   parameter int LENGTH     = 16,
   parameter int RETRIGGER  = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] trig,
   output logic [WIDTH-1:0] out,
   output logic             busy
);
   localparam int CW = $clog2(LENGTH + 1);
   localparam logic [CW-1:0] LOAD = CW'(LENGTH);
   localparam logic AL = (ACTIVE_LOW != 0);
   localparam logic RT = (RETRIGGER != 0);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [WIDTH-1:0] w_active_nxt;
   logic [WIDTH-1:0] r_out;
   logic             r_busy;

   for (genvar g = 0; g < WIDTH; g++) begin : ch
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      state_t        w_state;
      // channel state is just whether the count is nonzero; reload wins over decrement
      always_comb begin
         w_state   = (r_cnt != '0) ? ACTIVE : IDLE;
         w_cnt_nxt = (trig[g] && (w_state == IDLE || RT)) ? LOAD :
                     (w_state == ACTIVE && enable)        ? r_cnt - CW'(1) : r_cnt;
      end
      // per-channel hold counter
      always_ff @(posedge clk) begin
         if (rst) r_cnt <= '0;
         else     r_cnt <= w_cnt_nxt;
      end
      assign w_active_nxt[g] = (w_cnt_nxt != '0);
   end

   // outputs are flopped alongside the counters so they align with the count state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out  <= {WIDTH{AL}};
         r_busy <= 1'b0;
      end else begin
         r_out  <= w_active_nxt ^ {WIDTH{AL}};
         r_busy <= |w_active_nxt;
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed checks of the pulse stretcher across several parameter sets
module tb_pulse_stretcher;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       t1 = 1'b0;
   logic       t3 = 1'b0;
   logic [3:0] t4 = '0;
   logic       t5 = 1'b0;
   logic       o1, o2, o3, o5, b1, b2, b3, b4, b5;
   logic [3:0] o4;
   int         n_chk = 0;
   int         n_fail = 0;

   pulse_stretcher #(.WIDTH(1), .LENGTH(4), .RETRIGGER(1), .ACTIVE_LOW(0)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .trig(t1), .out(o1), .busy(b1));
   pulse_stretcher #(.WIDTH(1), .LENGTH(4), .RETRIGGER(0), .ACTIVE_LOW(0)) u2 (
      .clk(clk), .rst(rst), .enable(enable), .trig(t1), .out(o2), .busy(b2));
   pulse_stretcher #(.WIDTH(1), .LENGTH(3), .RETRIGGER(1), .ACTIVE_LOW(1)) u3 (
      .clk(clk), .rst(rst), .enable(enable), .trig(t3), .out(o3), .busy(b3));
   pulse_stretcher #(.WIDTH(4), .LENGTH(2), .RETRIGGER(1), .ACTIVE_LOW(0)) u4 (
      .clk(clk), .rst(rst), .enable(enable), .trig(t4), .out(o4), .busy(b4));
   pulse_stretcher #(.WIDTH(1), .LENGTH(8), .RETRIGGER(1), .ACTIVE_LOW(0)) u5 (
      .clk(clk), .rst(rst), .enable(enable), .trig(t5), .out(o5), .busy(b5));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tick();
      check("rst_during_o3", o3, 1);
      check("rst_during_o1", o1, 0);
      do_reset();
      check("rst_o1", o1, 0);
      check("rst_b1", b1, 0);
      check("rst_o3", o3, 1);
      check("rst_b3", b3, 0);
      check("rst_o4", o4, 0);
      check("rst_b4", b4, 0);
      check("rst_o5", o5, 0);

      // basic LENGTH=4 pulse, enable tied high (also counts enable in load cycle as not counted)
      enable = 1'b1;
      t1 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         t1 = 1'b0;
         check($sformatf("t1_out_k%0d", k), o1, k <= 3);
         check($sformatf("t1_busy_k%0d", k), b1, k <= 3);
      end

      // sparse enable: ticks at load+2, +6, +10, +14
      do_reset();
      enable = 1'b0;
      t1 = 1'b1;
      tick();
      t1 = 1'b0;
      check("t2_out_k0", o1, 1);
      for (int k = 1; k <= 15; k++) begin
         enable = (k % 4 == 2);
         tick();
         check($sformatf("t2_out_k%0d", k), o1, k < 14);
      end
      enable = 1'b1;

      // retrigger two cycles after first trig
      do_reset();
      for (int k = 0; k < 8; k++) begin
         t1 = (k == 0 || k == 2);
         tick();
         check($sformatf("t3_rt1_k%0d", k), o1, k <= 5);
         check($sformatf("t3_rt0_k%0d", k), o2, k <= 3);
      end
      t1 = 1'b0;

      // trig held high for six cycles
      do_reset();
      for (int k = 0; k < 11; k++) begin
         t1 = (k <= 5);
         tick();
         check($sformatf("hold_rt1_k%0d", k), o1, k <= 8);
         check($sformatf("hold_rt0_k%0d", k), o2, (k != 4) && (k <= 8));
      end
      t1 = 1'b0;

      // active-low output, LENGTH=3
      do_reset();
      t3 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         t3 = 1'b0;
         check($sformatf("t4_out_k%0d", k), o3, k >= 3);
         check($sformatf("t4_busy_k%0d", k), b3, k <= 2);
      end

      // independent channels, LENGTH=2
      do_reset();
      t4 = 4'b0101;
      tick();
      check("t5_out_k0", o4, 4'b0101);
      check("t5_busy_k0", b4, 1);
      t4 = 4'b1000;
      tick();
      t4 = 4'b0000;
      check("t5_out_k1", o4, 4'b1101);
      check("t5_busy_k1", b4, 1);
      tick();
      check("t5_out_k2", o4, 4'b1000);
      check("t5_busy_k2", b4, 1);
      tick();
      check("t5_out_k3", o4, 4'b0000);
      check("t5_busy_k3", b4, 0);

      // reset mid-pulse with trig asserted
      do_reset();
      t5 = 1'b1;
      tick();
      t5 = 1'b0;
      tick();
      tick();
      check("t6_pre_out", o5, 1);
      rst = 1'b1;
      t5 = 1'b1;
      tick();
      check("t6_rst_out", o5, 0);
      check("t6_rst_busy", b5, 0);
      rst = 1'b0;
      t5 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("t6_after_k%0d", k), o5, 0);
      end
      t5 = 1'b1;
      tick();
      t5 = 1'b0;
      check("t6_new_out", o5, 1);
      check("t6_new_busy", b5, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
